// File: rtl/vga_timing_gen.sv
// VGA raster timing: col/row/visible to the pixel logic, colour back through a
// sync/blank delay line matched to the pixel-logic latency, registered VGA pins.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          SYNC_POL   = 1'b0,
  parameter int unsigned PIPE_DELAY = 1
) (
  input  logic        vga_clk,
  input  logic        arst_n,
  output logic [9:0]  col,
  output logic [8:0]  row,
  output logic        visible,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_cnt,
  input  logic [3:0]  red_in,
  input  logic [3:0]  green_in,
  input  logic [3:0]  blue_in,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] COL_MAX  = 10'(H_ACTIVE - 1);
  localparam logic [8:0] ROW_MAX  = 9'(V_ACTIVE - 1);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        h_wrap, v_wrap, frame_wrap;
  logic        hs_raw, vs_raw;
  logic        vis_dly, hs_dly, vs_dly;

  always_comb begin
    h_wrap      = (h_cnt_q == H_LAST);
    v_wrap      = (v_cnt_q == V_LAST);
    frame_wrap  = h_wrap && v_wrap;
    h_cnt_d     = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
    v_cnt_d     = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = v_wrap ? 10'd0 : v_cnt_q + 10'd1;
    end
    frame_cnt_d = frame_cnt_q;
    if (frame_wrap) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_comb begin
    visible = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    col     = (h_cnt_q < H_ACT) ? h_cnt_q : COL_MAX;
    row     = (v_cnt_q < V_ACT) ? v_cnt_q[8:0] : ROW_MAX;
    hs_raw  = ((h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vs_raw  = ((v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? SYNC_POL : ~SYNC_POL;
  end

  assign frame_cnt = frame_cnt_q;

  always_ff @(posedge vga_clk or negedge arst_n) begin
    if (!arst_n) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      frame_cnt_q <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      line_start  <= h_wrap;
      frame_start <= frame_wrap;
    end
  end

  // Delay line matches sync/blank to the pixel-logic latency (0..4 stages).
  if (PIPE_DELAY == 0) begin : g_no_pipe
    assign vis_dly = visible;
    assign hs_dly  = hs_raw;
    assign vs_dly  = vs_raw;
  end else begin : g_pipe
    logic [PIPE_DELAY-1:0] vis_q, hs_q, vs_q;

    always_ff @(posedge vga_clk or negedge arst_n) begin
      if (!arst_n) begin
        vis_q <= '0;
        hs_q  <= {PIPE_DELAY{~SYNC_POL}};
        vs_q  <= {PIPE_DELAY{~SYNC_POL}};
      end else begin
        vis_q[0] <= visible;
        hs_q[0]  <= hs_raw;
        vs_q[0]  <= vs_raw;
        for (int i = 1; i < PIPE_DELAY; i++) begin
          vis_q[i] <= vis_q[i-1];
          hs_q[i]  <= hs_q[i-1];
          vs_q[i]  <= vs_q[i-1];
        end
      end
    end

    assign vis_dly = vis_q[PIPE_DELAY-1];
    assign hs_dly  = hs_q[PIPE_DELAY-1];
    assign vs_dly  = vs_q[PIPE_DELAY-1];
  end

  always_ff @(posedge vga_clk or negedge arst_n) begin
    if (!arst_n) begin
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      vga_hs <= ~SYNC_POL;
      vga_vs <= ~SYNC_POL;
    end else begin
      vga_r  <= vis_dly ? red_in : 4'h0;
      vga_g  <= vis_dly ? green_in : 4'h0;
      vga_b  <= vis_dly ? blue_in : 4'h0;
      vga_hs <= hs_dly;
      vga_vs <= vs_dly;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: full-size 640x480 instance (PIPE_DELAY=1) and a shrunken-raster instance
// (PIPE_DELAY=2) checked every cycle against an arithmetic raster model.
module tb_vga_timing_gen;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb, pd;
  } tim_t;

  typedef struct {
    int col, row, vis, ls, fs, fc, hs, vs, r, g, b;
  } outs_t;

  typedef struct {
    int t, col, hs, ls;
  } vec_t;

  localparam int MAXC = 5000;
  localparam int S_FT = 25 * 15;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic [3:0] red_in = '0, green_in = '0, blue_in = '0;

  logic [9:0]  f_col, s_col;
  logic [8:0]  f_row, s_row;
  logic        f_vis, s_vis, f_ls, s_ls, f_fs, s_fs, f_hs, s_hs, f_vs, s_vs;
  logic [15:0] f_fc, s_fc;
  logic [3:0]  f_r, f_g, f_b, s_r, s_g, s_b;

  int   hist [MAXC];
  int   checks = 0;
  int   failures = 0;
  tim_t pf, ps;
  vec_t tbl [14];

  always #5 clk = ~clk;

  vga_timing_gen dut_f (
    .vga_clk(clk), .arst_n(arst_n), .col(f_col), .row(f_row), .visible(f_vis),
    .line_start(f_ls), .frame_start(f_fs), .frame_cnt(f_fc),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .vga_r(f_r), .vga_g(f_g), .vga_b(f_b), .vga_hs(f_hs), .vga_vs(f_vs)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1'b0), .PIPE_DELAY(2)
  ) dut_s (
    .vga_clk(clk), .arst_n(arst_n), .col(s_col), .row(s_row), .visible(s_vis),
    .line_start(s_ls), .frame_start(s_fs), .frame_cnt(s_fc),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .vga_r(s_r), .vga_g(s_g), .vga_b(s_b), .vga_hs(s_hs), .vga_vs(s_vs)
  );

  task automatic cmp(input string name, input int t, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%0d expected=%0d", name, t, act, exp);
    end
  endtask

  // Raster model: position is plain arithmetic on cycles since reset release.
  function automatic outs_t model(input tim_t p, input int t, input int fc_base);
    outs_t o;
    int ht, vt, h, v, q, qh, qv;
    ht = p.ha + p.hf + p.hs + p.hb;
    vt = p.va + p.vf + p.vs + p.vb;
    h = t % ht;
    v = (t / ht) % vt;
    o.col = (h < p.ha) ? h : p.ha - 1;
    o.row = (v < p.va) ? v : p.va - 1;
    o.vis = (h < p.ha && v < p.va) ? 1 : 0;
    o.ls  = (t > 0 && h == 0) ? 1 : 0;
    o.fs  = (t > 0 && h == 0 && v == 0) ? 1 : 0;
    o.fc  = (fc_base + t / (ht * vt)) & 16'hFFFF;
    o.hs = 1; o.vs = 1; o.r = 0; o.g = 0; o.b = 0;
    if (t >= p.pd + 1) begin
      q  = t - 1 - p.pd;
      qh = q % ht;
      qv = (q / ht) % vt;
      o.hs = (qh >= p.ha + p.hf && qh < p.ha + p.hf + p.hs) ? 0 : 1;
      o.vs = (qv >= p.va + p.vf && qv < p.va + p.vf + p.vs) ? 0 : 1;
      if (qh < p.ha && qv < p.va) begin
        o.r = (hist[t-1] >> 8) & 15;
        o.g = (hist[t-1] >> 4) & 15;
        o.b = hist[t-1] & 15;
      end
    end
    return o;
  endfunction

  function automatic outs_t reset_outs();
    outs_t o;
    o = '{0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0};
    return o;
  endfunction

  function automatic outs_t get_f();
    outs_t o;
    o = '{int'(f_col), int'(f_row), int'(f_vis), int'(f_ls), int'(f_fs), int'(f_fc),
          int'(f_hs), int'(f_vs), int'(f_r), int'(f_g), int'(f_b)};
    return o;
  endfunction

  function automatic outs_t get_s();
    outs_t o;
    o = '{int'(s_col), int'(s_row), int'(s_vis), int'(s_ls), int'(s_fs), int'(s_fc),
          int'(s_hs), int'(s_vs), int'(s_r), int'(s_g), int'(s_b)};
    return o;
  endfunction

  task automatic check_outs(input string who, input int t, input outs_t a, input outs_t e);
    cmp({who, ".col"}, t, a.col, e.col);
    cmp({who, ".row"}, t, a.row, e.row);
    cmp({who, ".visible"}, t, a.vis, e.vis);
    cmp({who, ".line_start"}, t, a.ls, e.ls);
    cmp({who, ".frame_start"}, t, a.fs, e.fs);
    cmp({who, ".frame_cnt"}, t, a.fc, e.fc);
    cmp({who, ".vga_hs"}, t, a.hs, e.hs);
    cmp({who, ".vga_vs"}, t, a.vs, e.vs);
    cmp({who, ".vga_r"}, t, a.r, e.r);
    cmp({who, ".vga_g"}, t, a.g, e.g);
    cmp({who, ".vga_b"}, t, a.b, e.b);
  endtask

  // mode 0: all-F, 1: random, 2: red = small-raster col two cycles back
  task automatic drive(input int t, input int mode);
    int c, u, h;
    if (mode == 0) begin
      c = 12'hFFF;
    end else if (mode == 1) begin
      c = int'($urandom_range(0, 4095));
    end else begin
      c = int'($urandom_range(0, 255));
      if (t >= 2) begin
        u = t - 2;
        h = u % 25;
        c = c | ((((h < 16) ? h : 15) & 15) << 8);
      end
    end
    hist[t] = c;
    red_in   = 4'(c >> 8);
    green_in = 4'(c >> 4);
    blue_in  = 4'(c);
  endtask

  initial begin
    int runf, runs, runv, last_fs, mode, fcb_s, u;

    pf = '{640, 16, 96, 48, 480, 10, 2, 33, 1};
    ps = '{16, 2, 4, 3, 8, 2, 2, 3, 2};
    tbl = '{'{0, 0, 1, 0}, '{1, 1, 1, 0}, '{639, 639, 1, 0}, '{640, 639, 1, 0},
            '{657, 639, 1, 0}, '{658, 639, 0, 0}, '{753, 639, 0, 0}, '{754, 639, 1, 0},
            '{799, 639, 1, 0}, '{800, 0, 1, 1}, '{801, 1, 1, 0}, '{1458, 639, 0, 0},
            '{1554, 639, 1, 0}, '{1600, 0, 1, 1}};

    repeat (10) begin
      @(negedge clk);
      check_outs("f_rst", -1, get_f(), reset_outs());
      check_outs("s_rst", -1, get_s(), reset_outs());
    end
    @(posedge clk);
    #2 arst_n = 1'b1;

    runf = 0; runs = 0; runv = 0; last_fs = -1; fcb_s = 0;
    for (int t = 0; t <= 4635; t++) begin
      @(negedge clk);
      check_outs("f", t, get_f(), model(pf, t, 0));
      check_outs("s", t, get_s(), model(ps, t, fcb_s));
      for (int k = 0; k < 14; k++) begin
        if (tbl[k].t == t) begin
          cmp("tbl.col", t, int'(f_col), tbl[k].col);
          cmp("tbl.vga_hs", t, int'(f_hs), tbl[k].hs);
          cmp("tbl.line_start", t, int'(f_ls), tbl[k].ls);
        end
      end
      if (t <= 1700) begin
        if (f_r == 4'hF) runf++;
        else begin
          if (runf > 0) cmp("f.blank_run", t, runf, 640);
          runf = 0;
        end
        if (s_r == 4'hF) runs++;
        else begin
          if (runs > 0) cmp("s.blank_run", t, runs, 16);
          runs = 0;
        end
      end
      if (s_vs == 1'b0) begin
        if (runv == 0) cmp("s.vs_start", t, (t - 3) % S_FT, 250);
        runv++;
      end else begin
        if (runv > 0) cmp("s.vs_len", t, runv, 50);
        runv = 0;
      end
      if (s_fs) begin
        cmp("s.fs_period", t, t - last_fs, (last_fs < 0) ? t + 1 : S_FT);
        last_fs = t;
      end
      mode = (t < 1700) ? 0 : (t < 3400) ? 1 : 2;
      if (mode == 2 && t >= 3401) begin
        u = t - 3;
        if ((u % 25) < 16 && ((u / 25) % 15) < 8) cmp("s.pipe_r", t, int'(s_r), u % 25);
      end
      drive(t, mode);
    end

    // Mid-frame reset with the small raster at (h,v) = (10,5).
    #1 arst_n = 1'b0;
    #1;
    check_outs("f_mid_rst", -1, get_f(), reset_outs());
    check_outs("s_mid_rst", -1, get_s(), reset_outs());
    repeat (3) begin
      @(negedge clk);
      check_outs("f_mid_rst", -1, get_f(), reset_outs());
      check_outs("s_mid_rst", -1, get_s(), reset_outs());
    end
    @(posedge clk);
    #2 arst_n = 1'b1;

    for (int t = 0; t <= 800; t++) begin
      @(negedge clk);
      check_outs("f2", t, get_f(), model(pf, t, 0));
      check_outs("s2", t, get_s(), model(ps, t, fcb_s));
      if (t == 201) release dut_s.frame_cnt_d;
      drive(t, 1);
      if (t == 200) begin
        force dut_s.frame_cnt_d = 16'hFFFF;
        fcb_s = 65535 - (201 / S_FT);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
